// File: rtl/mem_arb_pkg.sv
// Shared widths and helpers for the memory-port arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ      = 2;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_READ_LATENCY = 1;

  // Owner-index width; a single-bit index is kept even for one or two masters.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the start index wins.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int IDX_W = idxWidth(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    logic             found;
    int               cand;
    logic [IDX_W-1:0] candIdx;
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int off = 0; off < N; off++) begin
      cand    = (int'(start_i) + off) % N;
      candIdx = IDX_W'(cand);
      if (!found && req_i[candIdx]) begin
        found          = 1'b1;
        gnt_o[candIdx] = 1'b1;
        idx_o          = candIdx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between NUM_REQ masters,
// with a per-master lock for read-modify-write and an in-order read-return tracker.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         data_out,
  output logic                      we,
  input  logic [DATA_W-1:0]         data_in
);

  localparam int IDX_W = idxWidth(NUM_REQ);
  localparam int DEPTH = READ_LATENCY + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0] addrArr  [NUM_REQ];
  logic [DATA_W-1:0] wdataArr [NUM_REQ];

  logic [IDX_W-1:0]   lastIdx_q, lastIdx_d;
  logic               locked_q, locked_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  dataOut_q, dataOut_d;
  logic               we_q, we_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [DEPTH-1:0]            trkValid_q;
  logic [DEPTH-1:0][IDX_W-1:0] trkOwner_q;

  logic [IDX_W-1:0]   startIdx, pickIdx, grantIdx;
  logic [NUM_REQ-1:0] pickGnt, lastOneHot;
  logic               lockHold, anyGrant, headValid;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addrArr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdataArr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  assign startIdx = (lastIdx_q == LAST_IDX) ? '0 : lastIdx_q + IDX_W'(1);

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .start_i (startIdx),
    .gnt_o   (pickGnt),
    .idx_o   (pickIdx)
  );

  // A held lock overrides round-robin only while its owner keeps requesting.
  assign lockHold   = locked_q && req[lastIdx_q];
  assign lastOneHot = NUM_REQ'(1) << lastIdx_q;
  assign anyGrant   = resetn && (|req);
  assign grantIdx   = lockHold ? lastIdx_q : pickIdx;
  assign gnt        = !resetn ? '0 : (lockHold ? lastOneHot : pickGnt);

  always_comb begin
    lastIdx_d = lastIdx_q;
    locked_d  = locked_q;
    addr_d    = addr_q;
    dataOut_d = dataOut_q;
    we_d      = 1'b0;
    headValid = 1'b0;
    if (anyGrant) begin
      lastIdx_d = grantIdx;
      locked_d  = req_lock[grantIdx];
      addr_d    = addrArr[grantIdx];
      dataOut_d = wdataArr[grantIdx];
      we_d      = req_we[grantIdx];
      headValid = !req_we[grantIdx];
    end else if (!req[lastIdx_q]) begin
      locked_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (trkValid_q[DEPTH-1]) begin
      rvalid_d = NUM_REQ'(1) << trkOwner_q[DEPTH-1];
      rdata_d  = data_in;
    end
  end

  // Reset also flushes the tracker so reads issued before it never return.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lastIdx_q  <= LAST_IDX;
      locked_q   <= 1'b0;
      addr_q     <= '0;
      dataOut_q  <= '0;
      we_q       <= 1'b0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      trkValid_q <= '0;
      trkOwner_q <= '0;
    end else begin
      lastIdx_q  <= lastIdx_d;
      locked_q   <= locked_d;
      addr_q     <= addr_d;
      dataOut_q  <= dataOut_d;
      we_q       <= we_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      trkValid_q <= {trkValid_q[DEPTH-2:0], headValid};
      trkOwner_q <= {trkOwner_q[DEPTH-2:0], grantIdx};
    end
  end

  assign address  = addr_q;
  assign data_out = dataOut_q;
  assign we       = we_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single synchronous memory port (`address`, `data_out`, `data_in`, `we`) between `NUM_REQ` masters. Typical masters are the multicycle core and a loader/DMA engine. The arbiter accepts at most one command per cycle, drives the memory port from registers, and routes read data back to the issuing master. A lock input lets one master hold the port for read-modify-write sequences.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `READ_LATENCY`, 1: cycles from `address` driven at the memory port until `data_in` is valid (1..4).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `req`  in  NUM_REQ  per-master command request.
- `req_we`  in  NUM_REQ  per-master write (1) or read (0).
- `req_lock`  in  NUM_REQ  per-master lock; while high with `req`, the master keeps ownership.
- `req_addr`  in  NUM_REQ*ADDR_W  flattened addresses, master i at slice i.
- `req_wdata`  in  NUM_REQ*DATA_W  flattened write data.
- `gnt`  out  NUM_REQ  one-hot, combinational; the command of master i is accepted this cycle.
- `rvalid`  out  NUM_REQ  one-hot, registered; read data for master i is on `rdata`.
- `rdata`  out  DATA_W  read data, shared by all masters.
- `address`  out  ADDR_W  memory address, registered.
- `data_out`  out  DATA_W  memory write data, registered.
- `we`  out  1  memory write enable, registered.
- `data_in`  in  DATA_W  memory read data.

## Operation
- **Arbitration.** Evaluated every cycle among masters with `req`=1.
  - Register `last` (index) holds the most recently granted master.
  - Lock rule: if `locked` is set and `req[last]`=1, `last` wins regardless of other requests.
  - Otherwise priority is round-robin starting at `last+1` (mod NUM_REQ).
  - Exactly one `gnt` bit is set when any `req` is set; `gnt`=0 when none is.
- **Acceptance.** A command is accepted on a rising edge with `gnt[i]`=1.
  - `address`, `data_out` and `we` are loaded from master i's slice.
  - `last` ← i.
  - `locked` ← `req_lock[i]`.
- **Cycles with no grant.**
  - `we` ← 0.
  - `address` and `data_out` hold their values.
  - `locked` ← 0 if `req[last]`=0.
- **Write path.** A write completes when the memory samples `we`=1. There is no write response.
- **Read tracking.**
  - A shift register of depth READ_LATENCY+1 carries {valid, owner index} for every accepted read.
  - At the tail, `rvalid[owner]` ← 1 and `rdata` ← `data_in`.
  - Reads return in issue order. Back-to-back reads from different masters are fully pipelined.
- **Masters.** Each master must hold `req`, `req_addr`, `req_wdata`, `req_we` and `req_lock` stable until it sees `gnt`.

## Timing
- Reset values:
  - `address`=0, `data_out`=0, `we`=0.
  - `rvalid`=0, `rdata`=0.
  - `last`=NUM_REQ-1, so master 0 has first priority.
  - `locked`=0, read tracker cleared.
- Reset mid-operation: in-flight reads are discarded. No `rvalid` is asserted after reset deasserts for reads accepted before it.
- Grant latency: 0 cycles (`gnt` is combinational in the request cycle).
- Memory command appears 1 cycle after acceptance.
- Read latency: `rvalid` rises READ_LATENCY+1 cycles after the acceptance edge.
  - Example, READ_LATENCY=1: accept at edge n → `address` valid after edge n → `data_in` valid after edge n+1 → `rvalid`/`rdata` valid after edge n+2.
- `rvalid` is a single-cycle pulse per read.
- Throughput: 1 command per cycle sustained.
- Simultaneous requests: exactly one grant; losers retry with no lost state.
- Wrap-around: the round-robin pointer wraps from NUM_REQ-1 to 0.
- A lock held by a master whose `req` drops is released in the same cycle. Arbitration that cycle is round-robin from `last+1`.

## Structure
- Shared package `mem_arb_pkg`:
  - default widths;
  - owner-index width, computed as `$clog2(NUM_REQ)` with a minimum of 1.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, start index.
  - Outputs: one-hot grant and encoded index.
- The read tracker and the lock/`last` registers live in the top module.

## Test plan
- **Single read.** NUM_REQ=2, READ_LATENCY=1. Master 0 reads 0x100, memory returns 0xDEADBEEF → `gnt`=01 in cycle 0; `address`=0x100, `we`=0 in cycle 1; `rvalid`=01, `rdata`=0xDEADBEEF in cycle 2.
- **Contention.** Both masters request every cycle for 4 cycles after reset → grants 01, 10, 01, 10. The `rvalid` sequence matches with correct data per owner.
- **Lock.** Master 1 issues a locked read of 0x40, then a write of 0x40 (`req_lock`=1), while master 0 requests continuously → both master-1 commands are granted consecutively. Master 0 is granted on the cycle after master 1 drops `req`.
- **Write.** Master 1 writes 0x55 to 0x200 → memory sees `we`=1, `address`=0x200, `data_out`=0x55 for exactly one cycle. No `rvalid` is produced.
- **Reset flush.** Read accepted, then `resetn`=0 one cycle later for 2 cycles → no `rvalid` ever. All outputs are 0 during reset, and master 0 wins the first post-reset tie.
- **Pipelined latency.** READ_LATENCY=3, reads alternate masters 0/1/0 back-to-back → three `rvalid` pulses on consecutive cycles starting 4 cycles after the first acceptance, with owners 0, 1, 0.
